// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with registered read port, status and sticky errors.
// Define STACK_PEEK_EN to add a combinational peek port (peek_idx/peek_data).
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
`ifdef STACK_PEEK_EN
    input  logic [CW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data,
`endif
    output logic             underflow
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             has_top, is_full;
    logic             do_replace, do_pop, do_push, do_tos, do_read;
    always_comb begin
        has_top     = count_q != '0;
        is_full     = count_q == CW'(DEPTH);
        top_idx     = AW'(count_q - CW'(1));
        wr_idx      = AW'(count_q);
        // push+pop on an empty stack degrades to a plain push (plus underflow)
        do_replace  = push & pop & has_top;
        do_pop      = pop & ~push & has_top;
        do_push     = push & ~(pop & has_top) & ~is_full;
        do_tos      = tos & ~push & ~pop & has_top;
        do_read     = do_replace | do_pop | do_tos;
        count_d     = do_push ? count_q + CW'(1) : do_pop ? count_q - CW'(1) : count_q;
        data_out_d  = do_read ? mem[top_idx] : data_out_q;
        out_valid_d = do_read;
        overflow_d  = (push & ~pop & is_full) | (overflow_q & ~clr_err);
        underflow_d = (pop & ~has_top) | (underflow_q & ~clr_err);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_idx] <= data_in;
        else if (do_replace)
            mem[top_idx] <= data_in;
    end
`ifdef STACK_PEEK_EN
    logic [CW-1:0] peek_pos;
    always_comb begin
        peek_pos  = count_q - CW'(1) - peek_idx;
        peek_data = (peek_idx < count_q) ? mem[AW'(peek_pos)] : '0;
    end
`endif
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign full      = is_full;
    assign empty     = ~has_top;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed self-checking bench for param_stack (WIDTH=8, DEPTH=8).
module tb_param_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             out_valid, full, empty, overflow, underflow;
    logic [CW-1:0]    count;
`ifdef STACK_PEEK_EN
    logic [CW-1:0]    peek_idx = '0;
    logic [WIDTH-1:0] peek_data;
`endif
    int checks = 0;
    int errors = 0;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .push(push), .pop(pop), .tos(tos),
        .clr_err(clr_err), .data_out(data_out), .out_valid(out_valid), .count(count),
        .full(full), .empty(empty), .overflow(overflow),
`ifdef STACK_PEEK_EN
        .peek_idx(peek_idx), .peek_data(peek_data),
`endif
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        push = 1'b1; data_in = d;
        step();
        push = 1'b0;
    endtask

    initial begin
        step();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", data_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        rst = 1'b0;
        step();

        // basic LIFO order
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        check("t1_count3", count, 3);
        pop = 1'b1;
        step();
        check("t1_pop1", data_out, 8'h33); check("t1_v1", out_valid, 1); check("t1_c1", count, 2);
        step();
        check("t1_pop2", data_out, 8'h22); check("t1_v2", out_valid, 1);
        step();
        check("t1_pop3", data_out, 8'h11); check("t1_v3", out_valid, 1);
        check("t1_empty", empty, 1); check("t1_c3", count, 0);
        pop = 1'b0;
        step();
        check("t1_vdrop", out_valid, 0); check("t1_hold", data_out, 8'h11);

        // fill, overflow, pop last valid word
        for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(8'h80 + i));
        check("t2_full", full, 1); check("t2_count8", count, 8);
        do_push(8'hAA);
        check("t2_ovf", overflow, 1); check("t2_count_sat", count, 8);
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("t2_pop", data_out, 8'h87); check("t2_count7", count, 7);
        check("t2_ovf_sticky", overflow, 1); check("t2_full0", full, 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t2_ovf_clr", overflow, 0);

        // reset then pop on empty
        rst = 1'b1;
        step();
        rst = 1'b0;
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("t3_unf", underflow, 1); check("t3_valid", out_valid, 0);
        check("t3_dout", data_out, 0); check("t3_count", count, 0);
        pop = 1'b1; clr_err = 1'b1;
        step();
        check("t3_unf_wins", underflow, 1);
        pop = 1'b0;
        step();
        clr_err = 1'b0;
        check("t3_unf_clr", underflow, 0);

        // replace-top, then tos
        do_push(8'h05);
        push = 1'b1; pop = 1'b1; data_in = 8'h06;
        step();
        push = 1'b0; pop = 1'b0;
        check("t4_rep_dout", data_out, 8'h05); check("t4_rep_valid", out_valid, 1);
        check("t4_rep_count", count, 1); check("t4_rep_unf", underflow, 0);
        tos = 1'b1;
        step();
        check("t4_tos", data_out, 8'h06); check("t4_tos_valid", out_valid, 1);
        check("t4_tos_count", count, 1);
        push = 1'b1; data_in = 8'h07;
        step();
        push = 1'b0; tos = 1'b0;
        check("t4_tos_ign_valid", out_valid, 0); check("t4_tos_ign_count", count, 2);
        // push+pop while empty: behaves as push, flags underflow
        rst = 1'b1; #2; rst = 1'b0;
        push = 1'b1; pop = 1'b1; data_in = 8'h42;
        step();
        push = 1'b0; pop = 1'b0;
        check("t4_pp_empty_count", count, 1); check("t4_pp_empty_unf", underflow, 1);
        check("t4_pp_empty_valid", out_valid, 0);
        tos = 1'b1;
        step();
        tos = 1'b0;
        check("t4_pp_empty_top", data_out, 8'h42);

        // async reset mid-sequence at count=4, no clock edge
        do_push(8'h01); do_push(8'h02); do_push(8'h03);
        check("t5_pre_count", count, 4);
        #1 rst = 1'b1;
        #2;
        check("t5_count", count, 0); check("t5_empty", empty, 1);
        check("t5_dout", data_out, 0); check("t5_valid", out_valid, 0);
        check("t5_unf", underflow, 0);
        rst = 1'b0;
        step();
        tos = 1'b1;
        step();
        tos = 1'b0;
        check("t5_tos_empty_valid", out_valid, 0); check("t5_tos_empty_unf", underflow, 0);

`ifdef STACK_PEEK_EN
        do_push(8'h01); do_push(8'h02); do_push(8'h03);
        peek_idx = 0; #1 check("t6_peek0", peek_data, 8'h03);
        peek_idx = 1; #1 check("t6_peek1", peek_data, 8'h02);
        peek_idx = 2; #1 check("t6_peek2", peek_data, 8'h01);
        peek_idx = 3; #1 check("t6_peek3", peek_data, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
